// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM arbiter.
package sdram_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;
    localparam int ADDR_W_DEF   = 23;
    localparam int DATA_W_DEF   = 32;
    localparam int REQ_RECORDER = 0;
    localparam int REQ_PLAYER   = 1;
    localparam int REQ_MIXER    = 2;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational winner select; round-robin from last_grant+1,
// or lowest index first when SDRAM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                valid = 1'b1;
                index = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] j;
    // Scan farthest-first so the nearest pending requester after last_grant wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (pending[j]) begin
                valid = 1'b1;
                index = j;
            end
        end
    end
`endif
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM command port among NUM_REQ requesters.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = REQ_MIXER + 1,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_writedata,
    output logic [DATA_W-1:0]               req_readdata,
    output logic [NUM_REQ-1:0]              req_finished,
    output logic                            sdram_read,
    output logic                            sdram_write,
    output logic [ADDR_W-1:0]               sdram_addr,
    output logic [DATA_W-1:0]               sdram_writedata,
    input  logic [DATA_W-1:0]               sdram_readdata,
    input  logic                            sdram_readdatavalid,
    input  logic                            sdram_waitrequest,
    output logic [1:0]                      debug
);
    localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d, last_grant_q, last_grant_d, pick_idx;
    logic                 pick_valid;
    logic                 read_q, read_d, write_q, write_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   finished_q, finished_d;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .pending    (req_read | req_write),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        finished_d   = '0;
        case (state_q)
            ST_IDLE: if (pick_valid) begin
                grant_d = pick_idx;
                write_d = req_write[pick_idx];
                read_d  = ~req_write[pick_idx];
                addr_d  = req_addr[pick_idx];
                wdata_d = req_writedata[pick_idx];
                state_d = ST_ISSUE;
            end
            ST_ISSUE: if (!sdram_waitrequest) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = write_q ? ST_DONE : ST_WAIT_RD;
                finished_d[grant_q] = write_q;
            end
            ST_WAIT_RD: if (sdram_readdatavalid) begin
                rdata_d = sdram_readdata;
                finished_d[grant_q] = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            finished_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            finished_q   <= finished_d;
        end
    end

    assign req_readdata    = rdata_q;
    assign req_finished    = finished_q;
    assign sdram_read      = read_q;
    assign sdram_write     = write_q;
    assign sdram_addr      = addr_q;
    assign sdram_writedata = wdata_q;
    assign debug           = state_q;
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (0 = recorder, 1 = player, 2 = mixer).
REQ-002 SHALL have parameter ADDR_W, default 23, SDRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 32, SDRAM data width.
REQ-004 SHALL have port i_clk, input, 1, sole clock; one clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port req_read, input, NUM_REQ, per-requester read request, held until its finished pulse.
REQ-007 SHALL have port req_write, input, NUM_REQ, per-requester write request, held until its finished pulse.
REQ-008 SHALL have port req_addr, input, NUM_REQ x ADDR_W, per-requester address.
REQ-009 SHALL have port req_writedata, input, NUM_REQ x DATA_W, per-requester write data.
REQ-010 SHALL have port req_readdata, output, DATA_W, shared registered read data, valid with finished.
REQ-011 SHALL have port req_finished, output, NUM_REQ, one-cycle completion pulse per requester.
REQ-012 SHALL have port sdram_read, output, 1, SDRAM read command.
REQ-013 SHALL have port sdram_write, output, 1, SDRAM write command.
REQ-014 SHALL have port sdram_addr, output, ADDR_W, SDRAM address.
REQ-015 SHALL have port sdram_writedata, output, DATA_W, SDRAM write data.
REQ-016 SHALL have port sdram_readdata, input, DATA_W, SDRAM read data.
REQ-017 SHALL have port sdram_readdatavalid, input, 1, read data strobe.
REQ-018 SHALL have port sdram_waitrequest, input, 1, command stall.
REQ-019 SHALL have port debug, output, 2, current FSM state encoding.

Function
REQ-020 SHALL implement FSM IDLE(0) -> ISSUE(1) -> WAIT_RD(2) -> DONE(3); all SDRAM-side outputs are registered.
REQ-021 SHALL, in IDLE with any request pending, latch the winner index, its command, its address and its write data, then enter ISSUE on the next edge.
REQ-022 SHALL hold sdram_read or sdram_write plus address and data constant in ISSUE while sdram_waitrequest=1.
REQ-023 SHALL, on ISSUE with waitrequest=0, deassert the command next cycle and go to DONE for a write or WAIT_RD for a read.
REQ-024 SHALL, in WAIT_RD on sdram_readdatavalid=1, capture sdram_readdata into req_readdata and go to DONE.
REQ-025 SHALL pulse req_finished[grant] for exactly one cycle in DONE and then return to IDLE; all other req_finished bits stay 0.
REQ-026 SHALL meet the latency targets when waitrequest=0: a request seen in IDLE at cycle 0 drives the command at cycle 1; a write gives finished at cycle 2; a read gives finished one cycle after readdatavalid.
REQ-027 SHALL treat read and write asserted together by one requester as a write.
REQ-028 SHALL complete a granted transaction and pulse finished even if the requester drops its request mid-transaction.
REQ-029 SHALL ignore sdram_readdatavalid outside WAIT_RD.
REQ-030 SHALL arbitrate round-robin by default: the search starts at last_grant+1 modulo NUM_REQ, and last_grant updates in DONE.
REQ-031 SHALL not re-grant a requester in the IDLE cycle immediately after its own DONE if another requester is pending (this follows from REQ-030).

Reset
REQ-032 SHALL, on i_rst=1 at an edge, set state IDLE, last_grant NUM_REQ-1, all command and finished outputs 0, and addr, writedata and req_readdata 0.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction with no finished pulse; a late readdatavalid is ignored per REQ-029.

Configuration
REQ-034 SHALL, with macro SDRAM_ARB_FIXED_PRIO_EN defined, grant the lowest-index pending requester (recorder first) and leave last_grant unused.
REQ-035 SHALL, without SDRAM_ARB_FIXED_PRIO_EN, use round-robin per REQ-030.

Structure
REQ-036 SHALL place the state enum, the ADDR_W and DATA_W defaults, and the requester index constants in package sdram_arb_pkg.
REQ-037 SHALL implement winner selection in combinational sub-module rr_picker (inputs pending and last_grant; outputs valid and index).

Verification
REQ-038 SHALL cover a single write: req_write[2]=1, addr 0x000100, data 0xDEADBEEF, waitrequest=0 -> sdram_write at cycle 1, req_finished[2] at cycle 2.
REQ-039 SHALL cover a single read: req_read[1] at addr 0x7FFFFF, readdatavalid 3 cycles after the command with 0x12345678 -> req_readdata=0x12345678 with req_finished[1] one cycle later.
REQ-040 SHALL cover round-robin: all three requesters hold reads -> grant order 0,1,2,0 with no requester starved.
REQ-041 SHALL cover a stall: waitrequest=1 for 5 cycles -> command, address and data stable for 6 cycles, exactly one finished pulse.
REQ-042 SHALL cover reset mid-read: i_rst in WAIT_RD, then readdatavalid -> no finished pulse, state IDLE, outputs 0.
REQ-043 SHALL cover fixed priority: with SDRAM_ARB_FIXED_PRIO_EN, requesters 0 and 2 pending continuously -> requester 0 granted every time.
